// File: rtl/mel_frame_sequencer.sv
// Frame-level controller for the mel filter bank MAC: buffers one frame of FFT bins,
// replays it once per filter, and streams each MAC result downstream.
module mel_frame_sequencer #(
    parameter int NUM_FILTERS = 8,
    parameter int FFT_SIZE    = 8,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         bin_in,
    input  logic                          bin_valid,
    output logic                          bin_ready,
    output logic [DATA_WIDTH-1:0]         mac_data,
    output logic                          mac_valid,
    input  logic [DATA_WIDTH-1:0]         mac_result,
    input  logic                          mac_result_valid,
    output logic [DATA_WIDTH-1:0]         mel_data,
    output logic                          mel_valid,
    input  logic                          mel_ready,
    output logic                          mel_last,
    output logic [$clog2(NUM_FILTERS):0]  mel_idx,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          err
);

    localparam int AW = $clog2(FFT_SIZE);
    localparam int PW = $clog2(FFT_SIZE) + 1;
    localparam int FW = $clog2(NUM_FILTERS) + 1;
    localparam logic [PW-1:0] LAST_BIN  = PW'(FFT_SIZE - 1);
    localparam logic [FW-1:0] LAST_FILT = FW'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        WAIT,
        OUT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] frame_buf [FFT_SIZE];
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [FW-1:0]         f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            wp         <= '0;
            rp         <= '0;
            f          <= '0;
            mel_data   <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            for (int unsigned i = 0; i < unsigned'(FFT_SIZE); i++) begin
                frame_buf[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            // A result strobe is only legal while waiting for one; the sequence itself is unaffected.
            if (mac_result_valid && (state != WAIT)) begin
                err <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (bin_valid) begin
                        frame_buf[wp[AW-1:0]] <= bin_in;
                        if (wp == LAST_BIN) begin
                            wp    <= '0;
                            rp    <= '0;
                            state <= RUN;
                        end else begin
                            wp <= wp + 1'b1;
                        end
                    end
                end
                RUN: begin
                    rp <= rp + 1'b1;
                    if (rp == LAST_BIN) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mac_result_valid) begin
                        mel_data <= mac_result;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (mel_ready) begin
                        if (f == LAST_FILT) begin
                            f          <= '0;
                            frame_done <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            f     <= f + 1'b1;
                            rp    <= '0;
                            state <= RUN;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Handshake outputs decode the registered state only, so no input reaches them combinationally.
    assign bin_ready = (state == LOAD);
    assign mac_valid = (state == RUN);
    assign mac_data  = mac_valid ? frame_buf[rp[AW-1:0]] : '0;
    assign mel_valid = (state == OUT);
    assign mel_last  = mel_valid && (f == LAST_FILT);
    assign mel_idx   = f;
    assign busy      = (state != LOAD);

endmodule

// File: tb/tb_mel_frame_sequencer.sv
// Randomized self-checking bench for mel_frame_sequencer with a behavioural MAC and frame model.
module tb_mel_frame_sequencer;

    localparam int NF = 8;
    localparam int FS = 8;
    localparam int DW = 16;
    localparam int IW = $clog2(NF) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] bin_in;
    logic          bin_valid;
    logic          bin_ready;
    logic [DW-1:0] mac_data;
    logic          mac_valid;
    logic [DW-1:0] mac_result;
    logic          mac_result_valid;
    logic [DW-1:0] mel_data;
    logic          mel_valid;
    logic          mel_ready;
    logic          mel_last;
    logic [IW-1:0] mel_idx;
    logic          busy;
    logic          frame_done;
    logic          err;

    mel_frame_sequencer #(
        .NUM_FILTERS(NF),
        .FFT_SIZE   (FS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bin_in          (bin_in),
        .bin_valid       (bin_valid),
        .bin_ready       (bin_ready),
        .mac_data        (mac_data),
        .mac_valid       (mac_valid),
        .mac_result      (mac_result),
        .mac_result_valid(mac_result_valid),
        .mel_data        (mel_data),
        .mel_valid       (mel_valid),
        .mel_ready       (mel_ready),
        .mel_last        (mel_last),
        .mel_idx         (mel_idx),
        .busy            (busy),
        .frame_done      (frame_done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            idx;
        bit            last;
    } mel_t;

    // Reference model: frame-level queues of what the MAC and downstream must see.
    logic [DW-1:0] bin_src[$];
    logic [DW-1:0] cur_bins[$];
    logic [DW-1:0] exp_mac[$];
    mel_t          exp_mel[$];
    bit            loading, done_due, err_exp, mac_pend, mel_pending_hs, hold_valid, directed;
    logic [DW-1:0] mac_res_val, hold_data;
    logic [IW-1:0] hold_idx;
    bit            hold_last;
    int            burst_cnt, mac_filt, cyc, run_t0, stalls;
    int            gap_mode, ready_mode, stall_left;
    bit            inject_req;

    task automatic clear_model();
        bin_src.delete();
        cur_bins.delete();
        exp_mac.delete();
        exp_mel.delete();
        loading        = 1'b1;
        done_due       = 1'b0;
        err_exp        = 1'b0;
        mac_pend       = 1'b0;
        mel_pending_hs = 1'b0;
        hold_valid     = 1'b0;
        burst_cnt      = 0;
        mac_filt       = 0;
        stalls         = 0;
        inject_req     = 1'b0;
    endtask

    task automatic apply_reset();
        #3;
        rst              = 1'b1;
        bin_valid        = 1'b0;
        mac_result_valid = 1'b0;
        mel_ready        = 1'b0;
        #1;
        check("rst_bin_ready", bin_ready, 1);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_mac_data", mac_data, 0);
        check("rst_mel_valid", mel_valid, 0);
        check("rst_mel_data", mel_data, 0);
        check("rst_mel_last", mel_last, 0);
        check("rst_mel_idx", mel_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step();
        bit            inject;
        bit            new_pend;
        logic [DW-1:0] new_res;
        mel_t          e;
        @(posedge clk);
        #1;
        cyc++;
        new_pend = 1'b0;
        new_res  = '0;

        check("bin_ready", bin_ready, loading);
        check("busy", busy, !loading);
        check("frame_done", frame_done, done_due);
        check("err", err, err_exp);
        if (frame_done && done_due) check("frame_latency", cyc - run_t0, NF * (FS + 2) + stalls);
        done_due = 1'b0;

        if (hold_valid) begin
            check("hold_valid", mel_valid, 1);
            check("hold_data", mel_data, hold_data);
            check("hold_idx", mel_idx, hold_idx);
            check("hold_last", mel_last, hold_last);
        end
        if (mel_valid && exp_mel.size() == 0) check("mel_unexpected", mel_valid, 0);

        if (mac_valid) begin
            if (mel_pending_hs) check("mac_quiet", mac_valid, 0);
            else if (exp_mac.size() == 0) check("mac_unexpected", mac_valid, 0);
            else begin
                if (burst_cnt == 0 && mac_filt == 0) begin
                    run_t0 = cyc;
                    stalls = 0;
                end
                check("mac_data", mac_data, exp_mac.pop_front());
                burst_cnt++;
                if (burst_cnt == FS) begin
                    burst_cnt      = 0;
                    mel_pending_hs = 1'b1;
                    new_pend       = 1'b1;
                    new_res        = directed ? DW'(16'h0100 + mac_filt) : DW'($urandom);
                    exp_mel.push_back('{data: new_res, idx: mac_filt, last: (mac_filt == NF - 1)});
                    mac_filt       = (mac_filt + 1) % NF;
                end
            end
        end else if (burst_cnt != 0) begin
            check("mac_burst", mac_valid, 1);
        end

        if (bin_src.size() > 0) begin
            case (gap_mode)
                0:       bin_valid = 1'b1;
                1:       bin_valid = ((cyc % 2) == 0);
                default: bin_valid = 1'($urandom_range(0, 1));
            endcase
            bin_in = bin_src[0];
        end else begin
            bin_valid = 1'b0;
            bin_in    = DW'($urandom);
        end
        if (frame_done && bin_valid) check("b2b_accept", bin_ready, 1);

        inject = inject_req && loading && !mac_pend;
        if (inject) inject_req = 1'b0;
        mac_result_valid = mac_pend || inject;
        mac_result       = mac_pend ? mac_res_val : DW'($urandom);
        mac_pend         = new_pend;
        mac_res_val      = new_res;

        case (ready_mode)
            0: mel_ready = 1'b1;
            1: mel_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (mel_valid && mel_idx == 3 && stall_left > 0) begin
                    mel_ready = 1'b0;
                    stall_left--;
                end else begin
                    mel_ready = 1'b1;
                end
            end
        endcase

        if (bin_valid && bin_ready) begin
            cur_bins.push_back(bin_in);
            void'(bin_src.pop_front());
            if (cur_bins.size() == FS) begin
                loading = 1'b0;
                for (int f = 0; f < NF; f++) begin
                    foreach (cur_bins[b]) exp_mac.push_back(cur_bins[b]);
                end
                cur_bins.delete();
            end
        end

        hold_valid = 1'b0;
        if (mel_valid && mel_ready && exp_mel.size() > 0) begin
            e = exp_mel.pop_front();
            check("mel_data", mel_data, e.data);
            check("mel_idx", mel_idx, e.idx);
            check("mel_last", mel_last, e.last);
            mel_pending_hs = 1'b0;
            if (e.last) begin
                done_due = 1'b1;
                loading  = 1'b1;
            end
        end else if (mel_valid) begin
            hold_valid = 1'b1;
            hold_data  = mel_data;
            hold_idx   = mel_idx;
            hold_last  = mel_last;
            stalls++;
        end

        if (inject) err_exp = 1'b1;
    endtask

    task automatic push_frame(input bit counting);
        for (int i = 0; i < FS; i++) bin_src.push_back(counting ? DW'(i + 1) : DW'($urandom));
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        bit idle;
        n = 0;
        do begin
            step();
            n++;
            idle = (bin_src.size() == 0) && (cur_bins.size() == 0) && (exp_mac.size() == 0) &&
                   (exp_mel.size() == 0) && !mac_pend && !done_due && loading;
        end while (!idle && n < max_cyc);
        check("idle_timeout", idle, 1);
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        bin_in           = '0;
        bin_valid        = 1'b0;
        mac_result       = '0;
        mac_result_valid = 1'b0;
        mel_ready        = 1'b0;
        cyc              = 0;
        apply_reset();

        // Directed frame: bins 1..8, results 0x0100+f, no backpressure.
        directed = 1'b1; gap_mode = 0; ready_mode = 0;
        push_frame(1'b1);
        run_until_idle(300);

        // Gapped input, 5-cycle stall on filter 3, stray result strobe in LOAD.
        directed = 1'b0; gap_mode = 1; ready_mode = 2; stall_left = 5; inject_req = 1'b1;
        push_frame(1'b0);
        run_until_idle(300);

        // Back-to-back frames: the next frame is offered while the current one runs.
        gap_mode = 0; ready_mode = 1;
        push_frame(1'b0);
        n = 0;
        while (loading && n < 50) begin step(); n++; end
        check("frame_c_loaded", loading, 0);
        push_frame(1'b0);
        run_until_idle(600);

        // Reset mid-RUN on filter 4, then a fresh frame.
        push_frame(1'b0);
        n = 0;
        while (!(mac_filt == 4 && burst_cnt == 3) && n < 400) begin step(); n++; end
        check("reach_filter4", (mac_filt == 4 && burst_cnt == 3), 1);
        apply_reset();
        ready_mode = 1;
        push_frame(1'b0);
        run_until_idle(400);

        for (int k = 0; k < 3; k++) begin
            gap_mode = $urandom_range(0, 2);
            push_frame(1'b0);
            run_until_idle(500);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mel_frame_sequencer.md
# mel_frame_sequencer

Frame-level controller for the fixed-point mel filter bank MAC. It buffers one frame of FFT_SIZE magnitude bins from the FFT stage, then replays the frame into the mel MAC once per filter. After each pass it collects the MAC result and presents it downstream on a valid/ready stream. It sits between the FFT magnitude stage and the log/DCT stage of the MFCC pipeline and keeps its filter count in lockstep with the MAC's internal filter index.

## Interface
- NUM_FILTERS, 8, number of mel filters per frame (≥1)
- FFT_SIZE, 8, bins per frame and bins per MAC pass (≥2)
- DATA_WIDTH, 16, width of bins and mel results
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- bin_in  in  DATA_WIDTH  FFT magnitude bin
- bin_valid  in  1  bin_in valid
- bin_ready  out  1  sequencer accepts a bin
- mac_data  out  DATA_WIDTH  bin to MAC (fft_mag_in)
- mac_valid  out  1  MAC input strobe (valid_in)
- mac_result  in  DATA_WIDTH  MAC output (mel_out)
- mac_result_valid  in  1  MAC output strobe (valid_out)
- mel_data  out  DATA_WIDTH  mel energy for filter mel_idx
- mel_valid  out  1  mel_data valid
- mel_ready  in  1  downstream accepts
- mel_last  out  1  marks the filter NUM_FILTERS-1 result
- mel_idx  out  $clog2(NUM_FILTERS)+1  current filter index
- busy  out  1  frame in progress (not LOAD)
- frame_done  out  1  one-cycle pulse after the last mel handshake
- err  out  1  sticky protocol error

## Operation
- Frame buffer: FFT_SIZE × DATA_WIDTH registers. Write pointer wp and read pointer rp are $clog2(FFT_SIZE)+1 bits. Filter counter f has the same width as mel_idx.
- State LOAD (the reset state):
  - bin_ready=1.
  - On bin_valid&&bin_ready: buf[wp]<=bin_in, wp++.
  - On the accept with wp==FFT_SIZE-1: wp<=0, rp<=0, go to RUN.
- State RUN:
  - mac_valid=1 and mac_data=buf[rp] every cycle, rp++.
  - When rp==FFT_SIZE-1: go to WAIT.
  - No stalls: exactly FFT_SIZE consecutive strobes.
- State WAIT:
  - mac_valid=0.
  - On mac_result_valid: mel_data<=mac_result, go to OUT.
  - Waits indefinitely for the result.
- State OUT:
  - mel_valid=1, mel_last=(f==NUM_FILTERS-1).
  - On mel_ready with f<NUM_FILTERS-1: f++, rp<=0, go to RUN.
  - On mel_ready with f==NUM_FILTERS-1: f<=0, frame_done<=1 for one cycle, go to LOAD.
- mel_data, mel_last and mel_idx stay stable while mel_valid && !mel_ready.
- mel_idx=f at all times.
- Bins are only accepted in LOAD. bin_valid outside LOAD is not consumed, and the upstream holds the bin.
- err is set when mac_result_valid is seen in any state other than WAIT. It is cleared only by rst, and the sequence continues regardless.
- No mid-frame abort. The sequencer and the MAC share rst, so both restart aligned at filter 0 / bin 0.
- Arithmetic: pointers and counters are plain binary and wrap only by explicit reset to 0. No data arithmetic is done here.

## Timing
- Reset values:
  - State LOAD; wp=rp=f=0.
  - bin_ready=1, mac_valid=0, mac_data=0, mel_valid=0, mel_data=0, mel_last=0, mel_idx=0.
  - busy=0, frame_done=0, err=0.
- bin_ready, mac_valid, mel_valid, mel_last and busy are decoded from the registered state; they have no combinational path from inputs. mac_data is read from registered buf/rp.
- Bin accept rate: one per cycle. The cycle after the FFT_SIZE-th accept is RUN cycle 0, with bin_ready=0.
- Per filter, with the MAC result arriving the cycle after the last strobe and mel_ready=1:
  - RUN: FFT_SIZE cycles.
  - WAIT: 1 cycle.
  - OUT: 1 cycle.
  - Total: FFT_SIZE+2 cycles.
- Frame latency from RUN entry to the last mel handshake is NUM_FILTERS×(FFT_SIZE+2) cycles. For the defaults this is 80.
- frame_done is high in the first LOAD cycle, and bin_ready=1 in that same cycle, so back-to-back frames are possible.
- mel_ready low stretches OUT; the MAC is idle meanwhile.
- Reset asserted mid-frame: all state and outputs return to their reset values immediately (asynchronously). Partial frame data is discarded.

## Test plan
- Defaults, bins 1..8 fed back-to-back, MAC model returns 0x0100+f one cycle after the 8th strobe, mel_ready=1:
  - 8 mac_valid bursts, each carrying data 1..8 in order.
  - mel_data 0x0100..0x0107 with mel_idx 0..7.
  - mel_last only with idx 7.
  - frame_done pulses 80 cycles after RUN entry.
- Backpressure: mel_ready low for 5 cycles on filter 3 → mel_valid held, mel_data/mel_idx stable, no mac_valid during the stall, and the frame completes 5 cycles late.
- Input gaps: bin_valid toggled 1/0 → exactly 8 bins stored in order, and bin_ready drops the cycle after the 8th accept.
- Back-to-back frames: the second frame's bins start in the frame_done cycle → accepted immediately, and the second frame's output matches the second frame's data.
- Protocol error: mac_result_valid pulsed during LOAD → err=1 and stays 1 through the rest of the frame; outputs are otherwise unaffected.
- Reset on filter 4 during RUN → all outputs at reset values. A new frame then starts at mel_idx 0 and runs correctly.
